// File: rtl/serial_link_peer.sv
// serial_link_peer: slave end of a DMG-style serial link; follows master sck.
// Ports: dffra_clk/nreset; sck/sin/sout line; tx_* holding reg; rx_* byte out; timeout.
module serial_link_peer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  IDLE_BYTE      = 8'hFF
) (
  input  logic       dffra_clk,
  input  logic       nreset,
  input  logic       sck,
  input  logic       sin,
  output logic       sout,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic            s1_q, s2_q, prev_q;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      tx_sr_q, tx_sr_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_ovr_q, rx_ovr_d;
  logic            sout_q, sout_d;
  logic            timeout_q, timeout_d;

  logic            fall, rise, byte_done, tmo_hit;
  logic [TW-1:0]   tmo_inc;
  logic [7:0]      rx_next;

  assign fall      = prev_q & ~s2_q;
  assign rise      = ~prev_q & s2_q;
  assign rx_next   = {rx_sr_q[6:0], sin};
  assign byte_done = (state_q == SHIFT) & rise & (bit_cnt_q == 3'd7);
  assign tmo_inc   = tmo_q + 1'b1;
  // Abort only when a whole window passes with no sck edge.
  assign tmo_hit   = (state_q == SHIFT) & ~(rise | fall) &
                     (tmo_inc == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge dffra_clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      prev_q      <= 1'b1;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      sout_q      <= 1'b1;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= sck;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      sout_q      <= sout_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall) state_d = SHIFT;
      SHIFT: if (byte_done | tmo_hit) state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = tmo_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_ovr_d    = rx_ovr_q;
    sout_d      = sout_q;
    timeout_d   = 1'b0;

    // A load racing the first fall lands here and waits for the next byte.
    if (tx_load && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall) begin
          if (hold_full_q) begin
            tx_sr_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            tx_sr_d = IDLE_BYTE;
          end
          sout_d    = tx_sr_d[7];
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (rise | fall) tmo_d = '0;
        else if (!tmo_hit) tmo_d = tmo_inc;
        if (fall) sout_d = tx_sr_q[7];
        if (rise) begin
          rx_sr_d   = rx_next;
          tx_sr_d   = tx_sr_q << 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) rx_data_d = rx_next;
        end
        if (tmo_hit) begin
          tmo_d     = '0;
          bit_cnt_d = '0;
          sout_d    = 1'b1;
          rx_sr_d   = '0;
          tx_sr_d   = '0;
          timeout_d = 1'b1;
        end
      end
    endcase

    if (rx_ack) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
    // A byte landing with the ack wins; overrun only if unacked.
    if (byte_done) begin
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) rx_ovr_d = 1'b1;
    end
  end

  assign sout       = sout_q;
  assign tx_ready   = ~hold_full_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_ovr_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_serial_link_peer.sv
// tb_serial_link_peer: directed bench for serial_link_peer.
// Drives a master-side sck/sin at 16 clk per bit and checks both directions.
module tb_serial_link_peer;

  logic       clk;
  logic       nreset;
  logic       sck;
  logic       sin;
  logic       sout;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  serial_link_peer dut (
    .dffra_clk (clk),
    .nreset    (nreset),
    .sck       (sck),
    .sin       (sin),
    .sout      (sout),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .rx_overrun(rx_overrun),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Master sends n bits MSB-first; optional tx_load on the fall-detect clk.
  task automatic send_bits(input logic [7:0] b, input int n,
                           input bit coll, input logic [7:0] cb,
                           output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      sin = b[7-i];
      repeat (2) @(negedge clk);
      if (coll && i == 0) begin
        tx_data = cb;
        tx_load = 1'b1;
      end
      @(negedge clk);
      tx_load = 1'b0;
      repeat (5) @(negedge clk);
      r = {r[6:0], sout};
      sck = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic ack_rx();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (sout !== 1'b1) begin
      errors++; $display("FAIL reset_sout got %b want 1", sout);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready);
    end
    checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rx got %h/%b want 00/0", rx_data, rx_valid);
    end
    checks++;
    if (rx_overrun !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b/%b want 0/0", rx_overrun, timeout);
    end
  endtask

  task automatic test_basic();
    logic [7:0] r;
    load_tx(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL load_tx_ready got %b want 0", tx_ready);
    end
    send_bits(8'h3C, 8, 1'b0, 8'h00, r);
    checks++;
    if (r !== 8'hA5) begin
      errors++; $display("FAIL basic_master_rx got %h want a5", r);
    end
    checks++;
    if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_rx got %h/%b want 3c/1", rx_data, rx_valid);
    end
    checks++;
    if (tx_ready !== 1'b1 || rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags got %b/%b want 1/0", tx_ready, rx_overrun);
    end
    ack_rx();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL basic_ack got %b want 0", rx_valid);
    end
  endtask

  task automatic test_idle_byte();
    logic [7:0] r;
    send_bits(8'h00, 8, 1'b0, 8'h00, r);
    checks++;
    if (r !== 8'hFF) begin
      errors++; $display("FAIL idle_master_rx got %h want ff", r);
    end
    checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL idle_rx got %h/%b want 00/1", rx_data, rx_valid);
    end
    ack_rx();
  endtask

  task automatic test_overrun();
    logic [7:0] r;
    send_bits(8'h11, 8, 1'b0, 8'h00, r);
    checks++;
    if (rx_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_first got %b want 0", rx_overrun);
    end
    send_bits(8'h22, 8, 1'b0, 8'h00, r);
    checks++;
    if (rx_data !== 8'h22 || rx_valid !== 1'b1 || rx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second got %h/%b/%b want 22/1/1",
               rx_data, rx_valid, rx_overrun);
    end
    ack_rx();
    checks++;
    if (rx_valid !== 1'b0 || rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_ack got %b/%b want 0/0", rx_valid, rx_overrun);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] r;
    int pulses;
    int first;
    load_tx(8'h77);
    send_bits(8'hC0, 3, 1'b0, 8'h00, r);
    checks++;
    if (r[2:0] !== 3'b011) begin
      errors++; $display("FAIL tmo_partial got %b want 011", r[2:0]);
    end
    pulses = 0;
    first = -1;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL tmo_pulses got %0d want 1", pulses);
    end
    checks++;
    if (first < 1000 || first > 1030) begin
      errors++; $display("FAIL tmo_time got %0d want 1000..1030", first);
    end
    checks++;
    if (sout !== 1'b1 || rx_valid !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tmo_state got %b/%b/%b want 1/0/1",
               sout, rx_valid, tx_ready);
    end
    send_bits(8'h5A, 8, 1'b0, 8'h00, r);
    checks++;
    if (rx_data !== 8'h5A || rx_valid !== 1'b1 || r !== 8'hFF) begin
      errors++;
      $display("FAIL tmo_next got %h/%b/%h want 5a/1/ff",
               rx_data, rx_valid, r);
    end
    ack_rx();
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int seen;
    send_bits(8'hC3, 5, 1'b0, 8'h00, r);
    load_tx(8'h99);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_load got %b want 0", tx_ready);
    end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if (sout !== 1'b1 || tx_ready !== 1'b1 || rx_data !== 8'h00 ||
        rx_valid !== 1'b0 || rx_overrun !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reset got %b%b %h %b%b%b want 11 00 000",
               sout, tx_ready, rx_data, rx_valid, rx_overrun, timeout);
    end
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rx_valid === 1'b1 || timeout === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rmid_quiet got %0d want 0", seen);
    end
    send_bits(8'h96, 8, 1'b0, 8'h00, r);
    checks++;
    if (rx_data !== 8'h96 || rx_valid !== 1'b1 || r !== 8'hFF) begin
      errors++;
      $display("FAIL rmid_next got %h/%b/%h want 96/1/ff",
               rx_data, rx_valid, r);
    end
    ack_rx();
  endtask

  task automatic test_load_collision();
    logic [7:0] r;
    send_bits(8'h01, 8, 1'b1, 8'hE7, r);
    checks++;
    if (r !== 8'hFF) begin
      errors++; $display("FAIL coll_now got %h want ff", r);
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL coll_hold got %b want 0", tx_ready);
    end
    ack_rx();
    send_bits(8'h02, 8, 1'b0, 8'h00, r);
    checks++;
    if (r !== 8'hE7 || tx_ready !== 1'b1 || rx_data !== 8'h02) begin
      errors++;
      $display("FAIL coll_next got %h/%b/%h want e7/1/02",
               r, tx_ready, rx_data);
    end
    ack_rx();
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    load_tx(8'h3C);
    send_bits(8'hA5, 8, 1'b0, 8'h00, r);
    load_tx(8'hC3);
    checks++;
    if (r !== 8'h3C || rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL b2b_first got %h/%h want 3c/a5", r, rx_data);
    end
    send_bits(8'h5A, 8, 1'b0, 8'h00, r);
    checks++;
    if (r !== 8'hC3 || rx_data !== 8'h5A || rx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got %h/%h/%b want c3/5a/1",
               r, rx_data, rx_overrun);
    end
    ack_rx();
  endtask

  initial begin
    nreset  = 1'b0;
    sck     = 1'b1;
    sin     = 1'b1;
    tx_data = 8'h00;
    tx_load = 1'b0;
    rx_ack  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    nreset = 1'b1;
    repeat (4) @(negedge clk);
    test_basic();
    test_idle_byte();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_load_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
